// File: rtl/hack_seq_ctrl_if.sv
// rtl/hack_seq_ctrl_if.sv - Hack sequencer bundle: instruction fetch, datapath execute and PC strobe signals.
interface hack_seq_ctrl_if;
  logic        cpu_reset;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        exec_valid;
  logic        exec_stall;
  logic        zr;
  logic        ng;
  logic [15:0] a_in;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  logic        fault;
  logic        halted;

  modport master (
    input  cpu_reset,
    output imem_req,
    input  imem_ack,
    input  imem_data,
    output instr,
    output exec_valid,
    input  exec_stall,
    input  zr,
    input  ng,
    input  a_in,
    input  pc_in,
    output pc_load,
    output pc_inc,
    output pc_reset,
    output fault,
    output halted
  );

  modport slave (
    output cpu_reset,
    input  imem_req,
    output imem_ack,
    output imem_data,
    input  instr,
    input  exec_valid,
    output exec_stall,
    output zr,
    output ng,
    output a_in,
    output pc_in,
    input  pc_load,
    input  pc_inc,
    input  pc_reset,
    input  fault,
    input  halted
  );
endinterface

// File: rtl/hack_seq_ctrl.sv
// rtl/hack_seq_ctrl.sv - Hack CPU fetch/execute sequencer with fetch timeout.
// Define HACK_SEQ_HALT_DETECT_EN to stop on the "(END) @END; 0;JMP" idiom.
module hack_seq_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic           clk,
  input  logic           rst,
  hack_seq_ctrl_if.master bus
);

`ifdef HACK_SEQ_HALT_DETECT_EN
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FAULT, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FAULT} state_t;
`endif

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_instr;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_inc;
  logic          r_fault;
  logic          w_is_c;
  logic          w_jump;
  logic          w_req;
  logic          w_exec_valid;
  logic          w_pc_load;
  logic          w_pc_inc;
  logic          w_pc_reset;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_is_c    = r_instr[15];
  // j3 (JGT) needs a strictly positive result, so it is dead when zr and ng are both set.
  assign w_jump    = (r_instr[2] & bus.ng) | (r_instr[1] & bus.zr) |
                     (r_instr[0] & ~bus.ng & ~bus.zr);

`ifdef HACK_SEQ_HALT_DETECT_EN
  logic w_halt_hit;
  logic r_halted;
  assign w_halt_hit = w_is_c && (r_instr[2:0] == 3'b111) &&
                      (bus.a_in == (bus.pc_in - 16'd1));
`else
  logic w_unused;
  assign w_unused = ^{bus.a_in, bus.pc_in};
`endif

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_exec_valid = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_reset   = 1'b0;
    if (!rst) begin
      if (bus.cpu_reset) begin
        w_pc_reset   = 1'b1;
        w_next_state = S_FETCH;
      end else begin
        case (r_state)
          S_FETCH: begin
            w_req = 1'b1;
            if (bus.imem_ack) begin
              w_next_state = S_EXEC;
            end else if (w_cnt_inc == TW'(ACK_TIMEOUT)) begin
              w_next_state = S_FAULT;
            end
          end
          S_EXEC: begin
            w_exec_valid = 1'b1;
            if (!bus.exec_stall) begin
              if (w_is_c && w_jump) begin
                w_pc_load = 1'b1;
              end else begin
                w_pc_inc = 1'b1;
              end
              w_next_state = S_FETCH;
`ifdef HACK_SEQ_HALT_DETECT_EN
              if (w_halt_hit) begin
                w_next_state = S_HALT;
              end
`endif
            end
          end
          S_FAULT: begin
            w_next_state = S_FAULT;
          end
`ifdef HACK_SEQ_HALT_DETECT_EN
          S_HALT: begin
            w_next_state = S_HALT;
          end
`endif
          default: begin
            w_next_state = S_FETCH;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_instr <= 16'h0000;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_fault <= (w_next_state == S_FAULT);
      if (bus.cpu_reset) begin
        r_cnt <= '0;
      end else if (r_state == S_FETCH) begin
        if (bus.imem_ack) begin
          r_instr <= bus.imem_data;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

`ifdef HACK_SEQ_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_next_state == S_HALT);
    end
  end
  assign bus.halted = rst ? 1'b0 : r_halted;
`else
  assign bus.halted = 1'b0;
`endif

  assign bus.imem_req   = w_req;
  assign bus.exec_valid = w_exec_valid;
  assign bus.pc_load    = w_pc_load;
  assign bus.pc_inc     = w_pc_inc;
  assign bus.pc_reset   = w_pc_reset;
  assign bus.instr      = rst ? 16'h0000 : r_instr;
  assign bus.fault      = rst ? 1'b0 : r_fault;

endmodule

// File: tb/tb_hack_seq_ctrl.sv
// tb/tb_hack_seq_ctrl.sv - Directed self-checking bench for hack_seq_ctrl.
module tb_hack_seq_ctrl;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  hack_seq_ctrl_if bus ();

  hack_seq_ctrl #(.ACK_TIMEOUT(15), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ack(input logic [15:0] data, input string tag);
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    #1;
    chk({tag, "_req"}, {15'd0, bus.imem_req}, 16'd1);
    cyc();
    bus.imem_ack = 1'b0;
  endtask

  task automatic exec_go(input logic zr, input logic ng, input logic exp_load,
                         input logic exp_inc, input logic [15:0] exp_instr, input string tag);
    bus.zr         = zr;
    bus.ng         = ng;
    bus.exec_stall = 1'b0;
    #1;
    chk({tag, "_valid"}, {15'd0, bus.exec_valid}, 16'd1);
    chk({tag, "_instr"}, bus.instr, exp_instr);
    chk({tag, "_load"}, {15'd0, bus.pc_load}, {15'd0, exp_load});
    chk({tag, "_inc"}, {15'd0, bus.pc_inc}, {15'd0, exp_inc});
    cyc();
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.cpu_reset  = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_data  = 16'hFFFF;
    bus.exec_stall = 1'b0;
    bus.zr         = 1'b0;
    bus.ng         = 1'b0;
    bus.a_in       = 16'h0000;
    bus.pc_in      = 16'h0000;
    cyc();
    cyc();
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_valid", {15'd0, bus.exec_valid}, 16'd0);
    chk("rst_strobes", {13'd0, bus.pc_load, bus.pc_inc, bus.pc_reset}, 16'd0);
    chk("rst_flags", {14'd0, bus.fault, bus.halted}, 16'd0);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;

    // Zero-wait ROM: two cycles per instruction.
    fetch_ack(16'h0005, "f1");
    exec_go(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, "a_inst");
    fetch_ack(16'hEC10, "f2");
    exec_go(1'b0, 1'b0, 1'b0, 1'b1, 16'hEC10, "c_nojmp");

    fetch_ack(16'hE302, "f3");
    exec_go(1'b1, 1'b0, 1'b1, 1'b0, 16'hE302, "jeq_t");
    fetch_ack(16'hE302, "f4");
    exec_go(1'b0, 1'b1, 1'b0, 1'b1, 16'hE302, "jeq_f");
    fetch_ack(16'hE301, "f5");
    exec_go(1'b0, 1'b0, 1'b1, 1'b0, 16'hE301, "jgt_t");
    fetch_ack(16'hE301, "f6");
    exec_go(1'b1, 1'b1, 1'b0, 1'b1, 16'hE301, "jgt_illegal");
    fetch_ack(16'hE304, "f7");
    exec_go(1'b0, 1'b1, 1'b1, 1'b0, 16'hE304, "jlt_t");
    fetch_ack(16'hE307, "f8");
    exec_go(1'b0, 1'b0, 1'b1, 1'b0, 16'hE307, "jmp_00");
    fetch_ack(16'hE307, "f9");
    exec_go(1'b1, 1'b1, 1'b1, 1'b0, 16'hE307, "jmp_11");
    fetch_ack(16'hE300, "f10");
    exec_go(1'b0, 1'b1, 1'b0, 1'b1, 16'hE300, "j000");

    // Datapath stall holds EXEC with no strobes.
    fetch_ack(16'h1234, "f11");
    bus.exec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", {15'd0, bus.exec_valid}, 16'd1);
      chk("stall_instr", bus.instr, 16'h1234);
      chk("stall_strobes", {14'd0, bus.pc_load, bus.pc_inc}, 16'd0);
      cyc();
    end
    exec_go(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, "stall_end");

    // Ack on the cycle that would time out wins.
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("wait_req", {15'd0, bus.imem_req}, 16'd1);
      chk("wait_fault", {15'd0, bus.fault}, 16'd0);
      cyc();
    end
    fetch_ack(16'h0042, "late_ack");
    exec_go(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, "late_exec");

    // No ack at all: fault after 15 FETCH cycles.
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("to_req", {15'd0, bus.imem_req}, 16'd1);
      chk("to_fault", {15'd0, bus.fault}, 16'd0);
      cyc();
    end
    #1;
    chk("fault_set", {15'd0, bus.fault}, 16'd1);
    chk("fault_req", {15'd0, bus.imem_req}, 16'd0);
    chk("fault_valid", {15'd0, bus.exec_valid}, 16'd0);
    chk("fault_strobes", {13'd0, bus.pc_load, bus.pc_inc, bus.pc_reset}, 16'd0);
    bus.imem_ack = 1'b1;
    cyc();
    #1;
    chk("fault_sticky", {15'd0, bus.fault}, 16'd1);
    chk("fault_ack_ign", {15'd0, bus.imem_req}, 16'd0);
    bus.imem_ack  = 1'b0;
    bus.cpu_reset = 1'b1;
    #1;
    chk("cpurst_strobes", {13'd0, bus.pc_load, bus.pc_inc, bus.pc_reset}, 16'd1);
    chk("cpurst_req", {15'd0, bus.imem_req}, 16'd0);
    cyc();
    bus.cpu_reset = 1'b0;
    #1;
    chk("cpurst_fault", {15'd0, bus.fault}, 16'd0);
    chk("cpurst_pcreset", {15'd0, bus.pc_reset}, 16'd0);
    chk("cpurst_refetch", {15'd0, bus.imem_req}, 16'd1);

    // cpu_reset overrides a taken jump in EXEC and leaves instr alone.
    fetch_ack(16'hE307, "f12");
    bus.cpu_reset = 1'b1;
    #1;
    chk("cr_exec_strobes", {13'd0, bus.pc_load, bus.pc_inc, bus.pc_reset}, 16'd1);
    cyc();
    bus.cpu_reset = 1'b0;
    #1;
    chk("cr_exec_instr", bus.instr, 16'hE307);
    chk("cr_exec_valid", {15'd0, bus.exec_valid}, 16'd0);
    chk("cr_exec_req", {15'd0, bus.imem_req}, 16'd1);

    // "(END) @END; 0;JMP" idiom.
    fetch_ack(16'hEA87, "f13");
    bus.pc_in = 16'h0010;
    bus.a_in  = 16'h000F;
    exec_go(1'b1, 1'b0, 1'b1, 1'b0, 16'hEA87, "halt_jmp");
`ifdef HACK_SEQ_HALT_DETECT_EN
    chk("halt_flag", {15'd0, bus.halted}, 16'd1);
    chk("halt_req", {15'd0, bus.imem_req}, 16'd0);
    cyc();
    #1;
    chk("halt_hold", {14'd0, bus.halted, bus.imem_req}, 16'd2);
`else
    chk("nohalt_flag", {15'd0, bus.halted}, 16'd0);
    chk("nohalt_req", {15'd0, bus.imem_req}, 16'd1);
    cyc();
    #1;
    chk("nohalt_hold", {14'd0, bus.halted, bus.imem_req}, 16'd1);
`endif
    bus.cpu_reset = 1'b1;
    cyc();
    bus.cpu_reset = 1'b0;
    bus.a_in      = 16'h0000;
    bus.pc_in     = 16'h0000;
    #1;
    chk("post_halt_flag", {15'd0, bus.halted}, 16'd0);
    chk("post_halt_req", {15'd0, bus.imem_req}, 16'd1);

    // rst in EXEC blanks every output that cycle and clears instr.
    fetch_ack(16'h7777, "f14");
    rst = 1'b1;
    #1;
    chk("mid_rst_instr", bus.instr, 16'h0000);
    chk("mid_rst_out", {12'd0, bus.exec_valid, bus.pc_load, bus.pc_inc, bus.imem_req}, 16'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("after_rst_instr", bus.instr, 16'h0000);
    chk("after_rst_req", {15'd0, bus.imem_req}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hack_seq_ctrl.md
Name: hack_seq_ctrl

Overview:
- Fetch/execute sequencer for the Hack CPU.
- Fetches each instruction over a req/ack handshake and presents it to the datapath for one or more EXEC cycles.
- Evaluates the C-instruction jump condition from the ALU flags and drives the load/inc/reset strobes of the program counter.
- Sits between instruction ROM, program counter and ALU/register datapath; the PC output drives the ROM address directly.

Parameters:
- ACK_TIMEOUT, 15: max consecutive FETCH cycles without imem_ack before entering FAULT; legal range 1..255.
- TW, 8: width of the internal timeout counter; must satisfy 2^TW > ACK_TIMEOUT.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- cpu_reset  input  1  Hack reset button; synchronous, restarts the program at address 0.
- imem_req  output  1  instruction fetch request.
- imem_ack  input  1  fetch complete; imem_data is valid in this cycle.
- imem_data  input  16  instruction word.
- instr  output  16  instruction register, stable for the whole of EXEC.
- exec_valid  output  1  high in EXEC; the datapath executes instr.
- exec_stall  input  1  datapath is not done; hold EXEC.
- zr  input  1  ALU out == 0, valid during EXEC.
- ng  input  1  ALU out < 0, valid during EXEC.
- a_in  input  16  current A register value (used by the optional feature).
- pc_in  input  16  current PC value (used by the optional feature).
- pc_load  output  1  PC load strobe (jump taken).
- pc_inc  output  1  PC increment strobe.
- pc_reset  output  1  PC clear strobe.
- fault  output  1  sticky fetch-timeout flag.
- halted  output  1  sticky halt flag (optional feature only, otherwise tied 0).

Behaviour:
- States: FETCH, EXEC, FAULT, HALT (HALT exists only with the optional feature). Registered state; registered instr, fault, halted and timeout counter. Strobes and imem_req are combinational from state and inputs.
- rst:
  - state=FETCH, instr=16'h0000, counter=0, fault=0, halted=0.
  - All outputs 0 during the rst cycle, including imem_req.
- Priority: rst > cpu_reset > normal operation.
- cpu_reset=1 in any state:
  - pc_reset=1 that cycle; pc_load=pc_inc=0; imem_req=0.
  - Next state FETCH; counter, fault and halted cleared; instr unchanged.
- FETCH:
  - imem_req=1.
  - If imem_ack: instr<=imem_data, counter<=0, next EXEC. An ack in the same cycle as the first req is legal (zero-wait ROM).
  - Else: counter<=counter+1. When counter+1 == ACK_TIMEOUT, next FAULT.
  - No PC strobes in FETCH.
- EXEC:
  - exec_valid=1; imem_req=0.
  - exec_stall=1: remain in EXEC; no strobes; flags ignored.
  - exec_stall=0: one strobe, then next FETCH.
    - A-instruction (instr[15]=0): pc_inc=1.
    - C-instruction: j1=instr[2], j2=instr[1], j3=instr[0]; jump=(j1&ng)|(j2&zr)|(j3&~ng&~zr).
    - jump=1: pc_load=1, pc_inc=0. jump=0: pc_inc=1, pc_load=0.
- pc_load and pc_inc are never both high. pc_reset is exclusive with both.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ack, then EXEC without stall).
- Strobes take effect at the end of the EXEC cycle, so the next FETCH presents the updated PC.
- FAULT:
  - fault=1; all strobes and imem_req 0; exec_valid 0.
  - Exit only via rst or cpu_reset.
- Simultaneous imem_ack and timeout in the same cycle: ack wins, next EXEC.
- zr=ng=1 is illegal from the ALU. jump is still computed by the formula above, and the j3 term is 0.

Optional Feature:
- Macro: HACK_SEQ_HALT_DETECT_EN.
- Enabled:
  - Trigger: in EXEC with exec_stall=0, C-instruction with instr[2:0]=3'b111 and a_in == pc_in-1 (mod 2^16). This is the "(END) @END; 0;JMP" idiom.
  - Response: pc_load=1 for that cycle as normal, next state HALT.
  - HALT: halted=1; no req, no strobes, exec_valid 0; exit only via rst or cpu_reset.
- Disabled: the HALT state is absent, halted is constant 0, and the unconditional jump executes normally forever.

Test Plan:
- rst, then ROM acks every req same cycle with 16'h0005 then 16'hEC10 (D=A) -> instr=0005 with exec_valid, pc_inc=1; next instr=EC10, pc_inc=1; 2 cycles per instruction.
- C-instr 16'hE302 (D;JEQ) with zr=1, ng=0 -> pc_load=1, pc_inc=0. Same instruction with zr=0, ng=1 -> pc_inc=1.
- JGT (j=001) with zr=0, ng=0 -> pc_load; JLT (j=100) with ng=1 -> pc_load; JMP (j=111) with any flags -> pc_load; j=000 -> pc_inc.
- exec_stall held 3 cycles in EXEC -> exec_valid high for 4 cycles, instr stable, exactly one strobe in the final cycle.
- ACK_TIMEOUT=15, imem_ack never asserted -> fault=1 after 15 FETCH cycles, then no strobes. Apply cpu_reset -> pc_reset=1 for 1 cycle, fault=0, imem_req=1 next cycle.
- With HACK_SEQ_HALT_DETECT_EN defined, pc_in=16'h0010, a_in=16'h000F, instr=16'hEA87 -> pc_load=1, then halted=1 with no further imem_req. Without the macro -> fetching continues and halted=0.
